// File: rtl/keystream_pixel_cipher.sv
// keystream_pixel_cipher
// Buffers finished key words from the keystream controller in a small FIFO
// and XORs one key per pixel into a valid/ready pixel stream. A frame counter
// restarts the diffusion chain and latches the cipher direction every
// FRAME_PIXELS pixels.
// Build option: define CIPHER_CHAIN_EN to enable chained diffusion; without it
// the chain term is zero and out_data = pix_data ^ key.
module keystream_pixel_cipher #(
  parameter int DATA_WIDTH   = 12,
  parameter int PIX_WIDTH    = 8,
  parameter int KEY_DEPTH    = 4,
  parameter int FRAME_PIXELS = 64,
  parameter logic [PIX_WIDTH-1:0] IV = PIX_WIDTH'(8'hA5)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_done,
  input  logic [DATA_WIDTH-1:0] key_in,
  output logic                  key_req,
  input  logic                  mode,
  input  logic                  pix_valid,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  pix_ready,
  output logic                  out_valid,
  output logic [PIX_WIDTH-1:0]  out_data,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  key_ovf
);

  localparam int AW = $clog2(KEY_DEPTH);
  localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(KEY_DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(FRAME_PIXELS - 1);

`ifdef CIPHER_CHAIN_EN
  localparam logic CHAIN_EN = 1'b1;
`else
  localparam logic CHAIN_EN = 1'b0;
`endif

  logic [PIX_WIDTH-1:0] key_mem [KEY_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          key_cnt;
  logic                 key_done_d;
  logic [CW-1:0]        pix_cnt;
  logic [PIX_WIDTH-1:0] chain_q;
  logic                 mode_q;
  logic                 out_last;

  logic                 key_edge, fifo_full, fifo_empty, fire, push;
  logic                 frame_start, frame_end, eff_mode;
  logic [PIX_WIDTH-1:0] head_key, chain_term, cipher;
  logic                 key_unused;

  // Key bits above PIX_WIDTH are intentionally dropped.
  assign key_unused  = ^key_in;

  assign key_edge    = key_done & ~key_done_d;
  assign fifo_full   = (key_cnt == DEPTH_C);
  assign fifo_empty  = (key_cnt == '0);
  assign key_req     = ~fifo_full;
  assign pix_ready   = ~fifo_empty & (~out_valid | out_ready);
  assign fire        = pix_valid & pix_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
  assign push        = key_edge & (~fifo_full | fire);

  assign head_key    = key_mem[rd_ptr];
  assign frame_start = (pix_cnt == '0);
  assign frame_end   = (pix_cnt == LAST_C);
  assign eff_mode    = frame_start ? mode : mode_q;
  assign chain_term  = CHAIN_EN ? (frame_start ? IV : chain_q) : '0;
  assign cipher      = pix_data ^ head_key ^ chain_term;
  assign frame_done  = out_valid & out_ready & out_last;

  // Key storage; emptiness is tracked by the counters, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) key_mem[wr_ptr] <= key_in[PIX_WIDTH-1:0];
  end

  // FIFO pointers, occupancy, key_done edge detect and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      key_cnt    <= '0;
      key_done_d <= 1'b0;
      key_ovf    <= 1'b0;
    end else begin
      key_done_d <= key_done;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fire) rd_ptr <= rd_ptr + 1'b1;
      case ({push, fire})
        2'b10:   key_cnt <= key_cnt + 1'b1;
        2'b01:   key_cnt <= key_cnt - 1'b1;
        default: key_cnt <= key_cnt;
      endcase
      if (key_edge && fifo_full && !fire) key_ovf <= 1'b1;
    end
  end

  // Output register, frame position, mode latch and diffusion chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      pix_cnt   <= '0;
      chain_q   <= IV;
      mode_q    <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= cipher;
      out_last  <= frame_end;
      pix_cnt   <= frame_end ? '0 : pix_cnt + 1'b1;
      mode_q    <= eff_mode;
      // Encrypt chains on the produced cipher, decrypt on the incoming cipher.
      chain_q   <= frame_end ? IV : (eff_mode ? pix_data : cipher);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keystream_pixel_cipher.sv
// Testbench for keystream_pixel_cipher: directed scenarios followed by random
// traffic, all checked against a queue-based reference model of the cipher.
module tb_keystream_pixel_cipher;

  localparam int DW    = 12;
  localparam int PW    = 8;
  localparam int DEPTH = 4;
  localparam int FP    = 3;
  localparam logic [7:0] IV = 8'hA5;

`ifdef CIPHER_CHAIN_EN
  localparam bit CHAIN = 1'b1;
  localparam logic [7:0] E_A = 8'h44;
  localparam logic [7:0] E_B = 8'h46;
`else
  localparam bit CHAIN = 1'b0;
  localparam logic [7:0] E_A = 8'hE1;
  localparam logic [7:0] E_B = 8'h02;
`endif

  logic clk = 1'b0;
  logic rst, key_done, mode, pix_valid, out_ready;
  logic [DW-1:0] key_in;
  logic [PW-1:0] pix_data;
  logic key_req, pix_ready, out_valid, frame_done, key_ovf;
  logic [PW-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0] keyq[$];
  bit         m_kd_prev, m_ovf, m_ov, m_last, m_fmode;
  logic [7:0] m_od, m_chain;
  int         m_idx;

  keystream_pixel_cipher #(
    .DATA_WIDTH(DW), .PIX_WIDTH(PW), .KEY_DEPTH(DEPTH),
    .FRAME_PIXELS(FP), .IV(IV)
  ) dut (
    .clk(clk), .rst(rst), .key_done(key_done), .key_in(key_in),
    .key_req(key_req), .mode(mode), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .frame_done(frame_done),
    .key_ovf(key_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    keyq.delete();
    m_kd_prev = 0; m_ovf = 0; m_ov = 0; m_last = 0; m_fmode = 0;
    m_od = '0; m_chain = IV; m_idx = 0;
  endtask

  // One clock: compare DUT outputs to the model mid-cycle, then advance the
  // model with the inputs that the next rising edge will see.
  task automatic step();
    bit rdy, fire;
    logic [7:0] k, o;
    @(negedge clk);
    rdy = (keyq.size() > 0) && (!m_ov || out_ready);
    check_val("key_req",    key_req,    (keyq.size() < DEPTH));
    check_val("pix_ready",  pix_ready,  rdy);
    check_val("out_valid",  out_valid,  m_ov);
    check_val("out_data",   out_data,   m_od);
    check_val("key_ovf",    key_ovf,    m_ovf);
    check_val("frame_done", frame_done, m_ov && out_ready && m_last);
    if (rst) begin
      model_reset();
    end else begin
      fire = pix_valid && rdy;
      if (fire) begin
        k = keyq.pop_front();
        if (m_idx == 0) begin
          m_fmode = mode;
          m_chain = IV;
        end
        o = pix_data ^ k ^ (CHAIN ? m_chain : 8'h00);
        m_chain = m_fmode ? pix_data : o;
        m_od = o;
        m_ov = 1;
        m_last = (m_idx == FP - 1);
        m_idx = (m_idx + 1) % FP;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (key_done && !m_kd_prev) begin
        if (keyq.size() < DEPTH) keyq.push_back(key_in[7:0]);
        else m_ovf = 1;
      end
      m_kd_prev = key_done;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(logic [DW-1:0] v);
    key_in = v; key_done = 1'b1; step();
    key_done = 1'b0; step();
  endtask

  task automatic do_reset();
    rst = 1'b1; step();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; key_done = 0; key_in = '0; mode = 0;
    pix_valid = 0; pix_data = '0; out_ready = 1;
    step(); step();
    rst = 1'b0;
    check_val("rst_key_req",   key_req,   1);
    check_val("rst_pix_ready", pix_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data",  out_data,  0);
    check_val("rst_key_ovf",   key_ovf,   0);

    // held key_done level captures exactly one word
    key_in = 12'h3C7; key_done = 1'b1;
    repeat (5) step();
    key_done = 1'b0;
    check_val("cap_ready", pix_ready, 1);
    check_val("cap_req",   key_req,   1);
    pix_valid = 1; pix_data = 8'h5A; step();
    pix_valid = 0;
    check_val("cap_once",  pix_ready, 0);
    step();

    // encrypt
    do_reset();
    push_key(12'h0F1); push_key(12'h122);
    mode = 0; out_ready = 1; pix_valid = 1;
    pix_data = 8'h10; step();
    check_val("enc_a", out_data, E_A);
    pix_data = 8'h20; step();
    check_val("enc_b", out_data, E_B);
    pix_valid = 0; step();

    // decrypt round trip
    do_reset();
    push_key(12'h0F1); push_key(12'h122);
    mode = 1; pix_valid = 1;
    pix_data = E_A; step();
    check_val("dec_a", out_data, 8'h10);
    pix_data = E_B; step();
    check_val("dec_b", out_data, 8'h20);
    pix_valid = 0; mode = 0; step();

    // backpressure
    do_reset();
    push_key(12'h111); push_key(12'h222); push_key(12'h333);
    out_ready = 0; pix_valid = 1; pix_data = 8'h33; step();
    pix_data = 8'h77;
    repeat (4) step();
    check_val("bp_hold_valid", out_valid, 1);
    check_val("bp_no_ready",   pix_ready, 0);
    out_ready = 1; step(); step();
    pix_valid = 0; step(); step();

    // overflow, then simultaneous pop and push on a full FIFO
    do_reset();
    for (int i = 1; i <= 5; i++) push_key(12'(i * 17));
    check_val("ovf_set",  key_ovf, 1);
    check_val("ovf_full", key_req, 0);
    key_in = 12'h0AB; key_done = 1; pix_valid = 1; pix_data = 8'h00; step();
    key_done = 0; pix_valid = 0;
    check_val("ovf_sticky",   key_ovf, 1);
    check_val("ovf_refilled", key_req, 0);
    pix_valid = 1;
    repeat (5) step();
    pix_valid = 0; step();

    // frame wrap with mid-frame mode change, then reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) push_key(12'($urandom));
    mode = 0; pix_valid = 1; pix_data = 8'h01; step();
    mode = 1; pix_data = 8'h02; step();
    pix_data = 8'h03; step();
    check_val("wrap_frame_done", frame_done, 1);
    pix_data = 8'h04; step();
    push_key(12'h5C3); push_key(12'h6D4);
    rst = 1; step(); rst = 0;
    check_val("midrst_valid", out_valid, 0);
    check_val("midrst_empty", pix_ready, 0);
    pix_valid = 0; mode = 0; step();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      key_done  = ($urandom_range(0, 2) == 0);
      key_in    = 12'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      pix_valid = $urandom_range(0, 1);
      pix_data  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
